// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the PIC16C5x fetch/decode/sequencing stage:
// ALU function codes, instruction field match values, skip classes and
// the Q1..Q4 phase encoding.
package instr_sequencer_pkg;

    localparam int INSTR_WIDTH    = 12;
    localparam int PC_WIDTH       = 9;
    localparam int FADDR_WIDTH    = 5;
    localparam int ALU_FUNC_WIDTH = 5;

    // ALU function codes
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IDLE  = 5'd0;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ADDWF = 5'd1;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SUBWF = 5'd2;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDWF = 5'd3;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORWF = 5'd4;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORWF = 5'd5;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_COMF  = 5'd6;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_DECF  = 5'd7;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_INCF  = 5'd8;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MOVF  = 5'd9;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RLF   = 5'd10;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RRF   = 5'd11;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SWAPF = 5'd12;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BCF   = 5'd13;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BSF   = 5'd14;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDLW = 5'd15;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORLW = 5'd16;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORLW = 5'd17;

    // Whole-word matches
    localparam logic [INSTR_WIDTH-1:0] NOP      = 12'h000;
    localparam logic [INSTR_WIDTH-1:0] OP_SLEEP = 12'h003;
    localparam logic [INSTR_WIDTH-1:0] OP_CLRW  = 12'h040;

    // Byte-oriented ops, matched on IR[11:6]
    localparam logic [5:0] OP_MISC   = 6'b000000;  // NOP/MOVWF/OPTION/SLEEP/CLRWDT/TRIS
    localparam logic [5:0] OP_CLR    = 6'b000001;  // CLRW/CLRF
    localparam logic [5:0] OP_SUBWF  = 6'b000010;
    localparam logic [5:0] OP_DECF   = 6'b000011;
    localparam logic [5:0] OP_IORWF  = 6'b000100;
    localparam logic [5:0] OP_ANDWF  = 6'b000101;
    localparam logic [5:0] OP_XORWF  = 6'b000110;
    localparam logic [5:0] OP_ADDWF  = 6'b000111;
    localparam logic [5:0] OP_MOVF   = 6'b001000;
    localparam logic [5:0] OP_COMF   = 6'b001001;
    localparam logic [5:0] OP_INCF   = 6'b001010;
    localparam logic [5:0] OP_DECFSZ = 6'b001011;
    localparam logic [5:0] OP_RRF    = 6'b001100;
    localparam logic [5:0] OP_RLF    = 6'b001101;
    localparam logic [5:0] OP_SWAPF  = 6'b001110;
    localparam logic [5:0] OP_INCFSZ = 6'b001111;

    // Bit and literal ops, matched on IR[11:8]
    localparam logic [3:0] OP_BCF    = 4'b0100;
    localparam logic [3:0] OP_BSF    = 4'b0101;
    localparam logic [3:0] OP_BTFSC  = 4'b0110;
    localparam logic [3:0] OP_BTFSS  = 4'b0111;
    localparam logic [3:0] OP_RETLW  = 4'b1000;
    localparam logic [3:0] OP_CALL   = 4'b1001;
    localparam logic [3:0] OP_MOVLW  = 4'b1100;
    localparam logic [3:0] OP_IORLW  = 4'b1101;
    localparam logic [3:0] OP_ANDLW  = 4'b1110;
    localparam logic [3:0] OP_XORLW  = 4'b1111;

    // GOTO, matched on IR[11:9]
    localparam logic [2:0] OP_GOTO   = 3'b101;

    // Conditional-skip classes
    localparam logic [1:0] SKIP_NONE = 2'd0;
    localparam logic [1:0] SKIP_ZERO = 2'd1;  // DECFSZ/INCFSZ: skip on zero ALU result
    localparam logic [1:0] SKIP_BCLR = 2'd2;  // BTFSC: skip when tested bit is 0
    localparam logic [1:0] SKIP_BSET = 2'd3;  // BTFSS: skip when tested bit is 1

    // One-hot instruction-cycle phase, bit order {Q4,Q3,Q2,Q1}
    typedef enum logic [3:0] {
        Q1 = 4'b0001,
        Q2 = 4'b0010,
        Q3 = 4'b0100,
        Q4 = 4'b1000
    } qState_t;

    // Resolve whether the current instruction skips the prefetched word.
    function automatic logic skipTaken(input logic [1:0] kind,
                                       input logic [7:0] fData,
                                       input logic [2:0] bitSel,
                                       input logic [7:0] aluResult);
        logic taken;
        taken = 1'b0;
        case (kind)
            SKIP_ZERO: taken = (aluResult == 8'h00);
            SKIP_BCLR: taken = ~fData[bitSel];
            SKIP_BSET: taken = fData[bitSel];
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Purely combinational instruction decoder: IR -> ALU function, literal,
// destination, STATUS update, branch class and skip class.
module instr_sequencer_decode
    import instr_sequencer_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0]    ir,
    output logic [ALU_FUNC_WIDTH-1:0] aluFunc,
    output logic [7:0]                literal,
    output logic                      litToW,
    output logic                      wDest,
    output logic                      fDest,
    output logic                      statusUpd,
    output logic                      isGoto,
    output logic                      isCall,
    output logic                      isRetlw,
    output logic                      isSleep,
    output logic [1:0]                skipKind
);

    // Set for byte-oriented ops whose destination comes from d = IR[5]
    logic isFop;

    // Opcode classification; anything not matched falls through as NOP
    always_comb begin
        aluFunc   = ALU_IDLE;
        literal   = ir[7:0];
        litToW    = 1'b0;
        wDest     = 1'b0;
        fDest     = 1'b0;
        statusUpd = 1'b0;
        isGoto    = 1'b0;
        isCall    = 1'b0;
        isRetlw   = 1'b0;
        isSleep   = 1'b0;
        skipKind  = SKIP_NONE;
        isFop     = 1'b0;

        if (ir[11:10] == 2'b00) begin
            case (ir[11:6])
                OP_MISC: begin
                    if (ir[5]) begin
                        // MOVWF: W passes through an OR with zero into f
                        aluFunc = ALU_IORLW;
                        literal = 8'h00;
                        fDest   = 1'b1;
                    end else if (ir == OP_SLEEP) begin
                        isSleep = 1'b1;
                    end
                end
                OP_CLR: begin
                    if (ir[5]) begin
                        // CLRF: AND with zero, result to f
                        aluFunc   = ALU_ANDLW;
                        literal   = 8'h00;
                        fDest     = 1'b1;
                        statusUpd = 1'b1;
                    end else if (ir == OP_CLRW) begin
                        aluFunc   = ALU_ANDLW;
                        literal   = 8'h00;
                        wDest     = 1'b1;
                        statusUpd = 1'b1;
                    end
                end
                OP_SUBWF:  begin aluFunc = ALU_SUBWF; isFop = 1'b1; statusUpd = 1'b1; end
                OP_DECF:   begin aluFunc = ALU_DECF;  isFop = 1'b1; statusUpd = 1'b1; end
                OP_IORWF:  begin aluFunc = ALU_IORWF; isFop = 1'b1; statusUpd = 1'b1; end
                OP_ANDWF:  begin aluFunc = ALU_ANDWF; isFop = 1'b1; statusUpd = 1'b1; end
                OP_XORWF:  begin aluFunc = ALU_XORWF; isFop = 1'b1; statusUpd = 1'b1; end
                OP_ADDWF:  begin aluFunc = ALU_ADDWF; isFop = 1'b1; statusUpd = 1'b1; end
                OP_MOVF:   begin aluFunc = ALU_MOVF;  isFop = 1'b1; statusUpd = 1'b1; end
                OP_COMF:   begin aluFunc = ALU_COMF;  isFop = 1'b1; statusUpd = 1'b1; end
                OP_INCF:   begin aluFunc = ALU_INCF;  isFop = 1'b1; statusUpd = 1'b1; end
                OP_RRF:    begin aluFunc = ALU_RRF;   isFop = 1'b1; statusUpd = 1'b1; end
                OP_RLF:    begin aluFunc = ALU_RLF;   isFop = 1'b1; statusUpd = 1'b1; end
                OP_SWAPF:  begin aluFunc = ALU_SWAPF; isFop = 1'b1; end
                OP_DECFSZ: begin aluFunc = ALU_DECF;  isFop = 1'b1; skipKind = SKIP_ZERO; end
                OP_INCFSZ: begin aluFunc = ALU_INCF;  isFop = 1'b1; skipKind = SKIP_ZERO; end
                default:   ;
            endcase
        end else if (ir[11:9] == OP_GOTO) begin
            isGoto = 1'b1;
        end else begin
            case (ir[11:8])
                OP_BCF:   begin aluFunc = ALU_BCF; fDest = 1'b1; end
                OP_BSF:   begin aluFunc = ALU_BSF; fDest = 1'b1; end
                OP_BTFSC: skipKind = SKIP_BCLR;
                OP_BTFSS: skipKind = SKIP_BSET;
                OP_RETLW: begin litToW = 1'b1; wDest = 1'b1; isRetlw = 1'b1; end
                OP_CALL:  isCall = 1'b1;
                OP_MOVLW: begin litToW = 1'b1; wDest = 1'b1; end
                OP_IORLW: begin aluFunc = ALU_IORLW; wDest = 1'b1; statusUpd = 1'b1; end
                OP_ANDLW: begin aluFunc = ALU_ANDLW; wDest = 1'b1; statusUpd = 1'b1; end
                OP_XORLW: begin aluFunc = ALU_XORLW; wDest = 1'b1; statusUpd = 1'b1; end
                default:  ;
            endcase
        end

        if (isFop) begin
            wDest = ~ir[5];
            fDest = ir[5];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// PIC16C5x instruction sequencer: Q1..Q4 phase FSM, instruction register,
// SLEEP handling and Q4-only strobe generation. Branches and taken skips
// replace the prefetched word with NOP so it executes as an idle cycle.
module instr_sequencer
    import instr_sequencer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INSTR_WIDTH-1:0]    progData,
    input  logic [7:0]                fData,
    input  logic [7:0]                aluResult,
    input  logic                      wakeIn,
    output logic [3:0]                qPhase,
    output logic [ALU_FUNC_WIDTH-1:0] aluFunc,
    output logic [2:0]                bitSel,
    output logic [7:0]                literal,
    output logic [FADDR_WIDTH-1:0]    fAddr,
    output logic                      litToW,
    output logic                      wWriteEn,
    output logic                      fWriteEn,
    output logic                      statusWriteEn,
    output logic                      pcInc,
    output logic                      pcLoad,
    output logic [PC_WIDTH-1:0]       pcLoadAddr,
    output logic                      stackPush,
    output logic                      stackPop,
    output logic                      sleeping
);

    qState_t                state;
    logic [INSTR_WIDTH-1:0] ir;

    logic       wDest;
    logic       fDest;
    logic       statusUpd;
    logic       isGoto;
    logic       isCall;
    logic       isRetlw;
    logic       isSleep;
    logic [1:0] skipKind;
    logic       flush;

    instr_sequencer_decode uDecode (
        .ir        (ir),
        .aluFunc   (aluFunc),
        .literal   (literal),
        .litToW    (litToW),
        .wDest     (wDest),
        .fDest     (fDest),
        .statusUpd (statusUpd),
        .isGoto    (isGoto),
        .isCall    (isCall),
        .isRetlw   (isRetlw),
        .isSleep   (isSleep),
        .skipKind  (skipKind)
    );

    assign qPhase = state;
    assign bitSel = ir[7:5];
    assign fAddr  = ir[4:0];

    // CALL targets only the lower page, so bit 8 is forced to zero
    assign pcLoadAddr = isCall ? {1'b0, ir[7:0]} : ir[8:0];

    // Any control transfer discards the prefetched word
    assign flush = isGoto | isCall | isRetlw |
                   skipTaken(skipKind, fData, ir[7:5], aluResult);

    // Phase FSM, IR load, sleep latch and strobes armed on Q3->Q4 only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= Q1;
            ir            <= NOP;
            sleeping      <= 1'b0;
            wWriteEn      <= 1'b0;
            fWriteEn      <= 1'b0;
            statusWriteEn <= 1'b0;
            pcInc         <= 1'b0;
            pcLoad        <= 1'b0;
            stackPush     <= 1'b0;
            stackPop      <= 1'b0;
        end else begin
            wWriteEn      <= 1'b0;
            fWriteEn      <= 1'b0;
            statusWriteEn <= 1'b0;
            pcInc         <= 1'b0;
            pcLoad        <= 1'b0;
            stackPush     <= 1'b0;
            stackPop      <= 1'b0;
            case (state)
                Q1: begin
                    if (!sleeping) begin
                        state <= Q2;
                    end else if (wakeIn) begin
                        sleeping <= 1'b0;
                        state    <= Q2;
                    end
                end
                Q2: state <= Q3;
                Q3: begin
                    state         <= Q4;
                    wWriteEn      <= wDest;
                    fWriteEn      <= fDest;
                    statusWriteEn <= statusUpd;
                    pcLoad        <= isGoto | isCall;
                    pcInc         <= ~(isGoto | isCall | isRetlw | isSleep);
                    stackPush     <= isCall;
                    stackPop      <= isRetlw;
                end
                Q4: begin
                    state <= Q1;
                    ir    <= flush ? NOP : progData;
                    if (isSleep) begin
                        sleeping <= 1'b1;
                    end
                end
                default: state <= Q1;
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/sequencing stage directly upstream of the ALU in the PIC16C5x core.
- Generates the four-phase Q1..Q4 instruction cycle and holds the prefetched 12-bit instruction in an instruction register (IR).
- Decodes the IR into the ALU function code, literal, bit select, register address and write enables.
- Resolves GOTO/CALL/RETLW and conditional skips by flushing the prefetched instruction to a NOP.

Parameters:
- INSTR_WIDTH, 12, program word width.
- PC_WIDTH, 9, program-counter / branch-target width (CALL uses an 8-bit target, zero-extended with bit 8 = 0).
- FADDR_WIDTH, 5, register-file address width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous reset, active-low.
- progData  in  INSTR_WIDTH  program-memory word at the current PC; sampled at the end of Q4.
- fData  in  8  register-file read data for IR f-field; used for the BTFSC/BTFSS bit test.
- aluResult  in  8  ALU result; used for the DECFSZ/INCFSZ zero test.
- wakeIn  in  1  wake from SLEEP (level).
- qPhase  out  4  one-hot phase {Q4,Q3,Q2,Q1}.
- aluFunc  out  ALU_FUNC_WIDTH  ALU function code.
- bitSel  out  3  IR[7:5].
- literal  out  8  IR[7:0]; forced to 0 for MOVWF/CLRF/CLRW.
- fAddr  out  FADDR_WIDTH  IR[4:0].
- litToW  out  1  W is loaded from literal, bypassing the ALU (MOVLW, RETLW).
- wWriteEn  out  1  W write strobe.
- fWriteEn  out  1  register-file write strobe.
- statusWriteEn  out  1  STATUS update strobe.
- pcInc  out  1  PC increment strobe.
- pcLoad  out  1  PC load strobe.
- pcLoadAddr  out  PC_WIDTH  PC load target.
- stackPush  out  1  push return address (CALL).
- stackPop  out  1  pop return address (RETLW).
- sleeping  out  1  core halted by SLEEP.

Behaviour:
- Reset (async, rst_n=0):
  - qPhase=0001 (Q1); IR=12'h000 (NOP); sleeping=0.
  - All strobes 0; aluFunc=ALU_IDLE.
  - Reset applied mid-cycle aborts the instruction in flight; no strobe fires.
- Phase counter: Q1->Q2->Q3->Q4->Q1, one clk per phase. One instruction cycle is 4 clks.
- Decode:
  - aluFunc/bitSel/literal/fAddr/litToW are combinational from IR and stable Q1..Q4.
- Strobes:
  - wWriteEn/fWriteEn/statusWriteEn/pcInc/pcLoad/stackPush/stackPop are high only while qPhase=Q4 (exactly 1 clk per instruction cycle).
- Opcode mapping to ALU functions (ALU funcs from define.v):
  - ADDWF/SUBWF/ANDWF/IORWF/XORWF/COMF/DECF/INCF/MOVF/RLF/RRF/SWAPF/BCF/BSF/ANDLW/IORLW/XORLW map to the same-named ALU function.
  - DECFSZ->ALU_DECF; INCFSZ->ALU_INCF.
  - MOVWF->ALU_IORLW with literal=0.
  - CLRF/CLRW->ALU_ANDLW with literal=0.
  - MOVLW/RETLW: litToW=1, aluFunc=ALU_IDLE.
  - NOP/GOTO/CALL/BTFSC/BTFSS/SLEEP/CLRWDT/OPTION/TRIS: ALU_IDLE, no W/f/status write.
- Destination for f-ops: d=IR[5]. d=0 -> wWriteEn; d=1 -> fWriteEn.
  - MOVWF/CLRF/BCF/BSF -> fWriteEn.
  - CLRW/literal ops -> wWriteEn.
- statusWriteEn:
  - ADDWF/SUBWF/RLF/RRF (C, and DC where the ALU produces it).
  - ANDWF/IORWF/XORWF/COMF/DECF/INCF/MOVF/CLRF/CLRW/ANDLW/IORLW/XORLW (Z).
  - 0 for all other opcodes.
- Branches, driven at Q4:
  - GOTO: pcLoad=1, pcLoadAddr=IR[8:0].
  - CALL: pcLoad=1, pcLoadAddr={1'b0,IR[7:0]}, stackPush=1.
  - RETLW: stackPop=1; pcLoad=0 (the stack drives the PC).
  - pcInc=1 on every other Q4 while not sleeping.
- Skip taken, evaluated at Q4:
  - DECFSZ/INCFSZ when aluResult==0.
  - BTFSC when fData[bitSel]==0.
  - BTFSS when fData[bitSel]==1.
- IR update on the Q4->Q1 edge:
  - IR <= 12'h000 if (GOTO|CALL|RETLW|skip taken); else IR <= progData.
  - Effect: the flushed slot executes as a 1-cycle NOP. Branches cost 2 cycles.
- SLEEP:
  - At Q4, sleeping<=1, pcInc=0.
  - Phase freezes at Q1 with all strobes 0 while sleeping.
  - wakeIn=1 in Q1 clears sleeping; Q2 follows on the next clk.
  - wakeIn asserted at the same edge that sets sleeping has no effect until the next Q1.
- Unlisted opcodes behave as NOP.

Decomposition:
- define.v: ALU_FUNC_WIDTH and ALU_* codes (existing); add INSTR_WIDTH, opcode match constants (OP_GOTO=3'b101, OP_CALL=4'b1001, etc.), and NOP=12'h000.
- One natural sub-module, instr_decode: purely combinational, IR -> aluFunc/literal/dest/branch/skip-class.
- instr_sequencer keeps the Q FSM, IR, sleep and strobe gating.

Test Plan:
- Reset, then progData=0x1C5 (ADDWF f5,d=0) -> first cycle executes NOP. Second cycle: aluFunc=ALU_ADDWF, fAddr=5, wWriteEn & statusWriteEn only in Q4, pcInc each Q4.
- IR=0xA23 (GOTO 0x023) -> Q4: pcLoad=1, pcLoadAddr=0x023, pcInc=0. Next cycle IR=0x000 regardless of progData.
- DECFSZ 0x2E7 with aluResult=0x00 -> next IR flushed to NOP. With aluResult=0x01 -> next IR=progData.
- BTFSS 0x763 (bit 3, f3), fData=0x08 -> skip. fData=0x00 -> no skip. BTFSC with same data -> inverted result.
- CALL 0x955 -> pcLoadAddr=0x055, stackPush=1. RETLW 0x8AA -> litToW=1, literal=0xAA, wWriteEn=1, stackPop=1. Each followed by a NOP slot.
- SLEEP 0x003 -> sleeping=1, qPhase held 0001, no strobes for 20 clks. wakeIn=1 -> Q2 next clk. rst_n pulse during Q3 -> immediate Q1, IR=0, strobes 0.
